multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset datapath (regfile, ALU, sign-extend, PC muxes, inst/data memory).
//  Replaces the single-cycle combinational decode: it sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//  It handshakes with instruction and data memory, and emits per-state enables and mux selects.
//  Illegal opcodes and memory timeouts stop the core in HALT.
// PARAMETERS
//  TIMEOUT_W  8  width of memory-wait counter; a wait of 2**TIMEOUT_W-1 cycles without ready -> HALT
// PORTS
//  clk            in   1  rising-edge clock
//  rst_n          in   1  asynchronous active-low reset
//  opcode         in   6  instr[31:26] from instruction memory; sampled in FETCH when imem_ready=1
//  funct          in   6  instr[5:0]; sampled with opcode
//  alu_zero       in   1  ALU zero flag; sampled in EXECUTE
//  imem_ready     in   1  instruction word valid
//  dmem_ready     in   1  data memory access complete
//  imem_req       out  1  instruction fetch request
//  dmem_req       out  1  data memory access request
//  ir_wr_en       out  1  latch instruction register
//  pc_wr_en       out  1  update PC from pc_src mux
//  reg_wr_en      out  1  register-file write strobe
//  mem_wr_en      out  1  data-memory write (with dmem_req)
//  pc_src         out  2  0 pc+4, 1 rs (jr), 2 jump absolute, 3 branch target
//  writeback_src  out  2  0 aluOut, 1 dataMemOut, 2 pc+4
//  reg_dst        out  1  0 rd, 1 rt
//  link_sel       out  1  1 forces write register = 31 (jal)
//  alu_src_b      out  1  0 ReadData2, 1 extended immediate
//  ext_sel        out  1  1 sign-extend, 0 zero-extend
//  alu_command    out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT
//  state          out  3  0 RESET,1 FETCH,2 DECODE,3 EXECUTE,4 MEMORY,5 WRITEBACK,6 HALT
//  halt_cause     out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
// BEHAVIOUR
//  - Reset (rst_n low, any time, mid-instruction included): state=RESET; op/funct regs, wait counter, halt_cause=0.
//    All outputs decode from state + op/funct regs, so every output is 0 in RESET.
//  - RESET -> FETCH on the first clk edge with rst_n high.
//  - FETCH: imem_req=1. On imem_ready: ir_wr_en=1, capture opcode/funct, -> DECODE. Else counter++.
//  - DECODE: one cycle; rs/rt read. Legal op -> EXECUTE; illegal op -> HALT, cause 1.
//  - Supported ops: R-type(op 0x00) funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08; LW 0x23; SW 0x2B; XORI 0x0E;
//    BNE 0x05; J 0x02; JAL 0x03. Any other op or R-funct is illegal.
//  - EXECUTE, per op:
//    R-type: alu_command per funct; alu_src_b=0; -> WRITEBACK.
//    LW/SW: ADD, alu_src_b=1, ext_sel=1; -> MEMORY.
//    XORI: XOR, alu_src_b=1, ext_sel=0; -> WRITEBACK.
//    BNE: SUB, ext_sel=1, pc_wr_en=1, pc_src=3 if alu_zero==0 else 0; -> FETCH.
//    J: pc_wr_en=1, pc_src=2; -> FETCH.
//    JR: pc_wr_en=1, pc_src=1; -> FETCH.
//    JAL: pc_wr_en=1, pc_src=2, reg_wr_en=1, link_sel=1, writeback_src=2; -> FETCH.
//  - MEMORY: dmem_req=1, ALU selects held; SW also asserts mem_wr_en=1.
//    On dmem_ready: SW pulses pc_wr_en (pc_src=0) -> FETCH; LW -> WRITEBACK. Else counter++.
//  - WRITEBACK: reg_wr_en=1, pc_wr_en=1, pc_src=0.
//    R-type: reg_dst=0, wb=0. XORI: reg_dst=1, wb=0. LW: reg_dst=1, wb=1. -> FETCH.
//  - Strobes reg_wr_en, pc_wr_en, ir_wr_en are high exactly one cycle per instruction.
//  - Latency in cycles excluding memory waits: R/XORI 4, LW 5, SW 4, BNE/J/JR/JAL 3.
//  - Wait counter: cleared on every state change; saturating. If it reaches 2**TIMEOUT_W-1 in FETCH or MEMORY
//    with ready still 0 -> HALT, cause 2 or 3. Ready arriving on that same edge wins (no halt).
//  - HALT: all strobes and requests 0; halt_cause held; exits only via rst_n.
//  - Ready inputs are ignored outside their own request state.
// TESTING
//  1. Reset release, imem_ready=1 with ADD (op 0,funct 0x20): state 0->1->2->3->5->1; reg_wr_en and pc_wr_en only in cycle 4.
//  2. LW with dmem_ready delayed 3 cycles: MEMORY held 4 cycles with dmem_req=1; WRITEBACK asserts reg_dst=1, writeback_src=1.
//  3. BNE with alu_zero=0 -> pc_src=3; with alu_zero=1 -> pc_src=0; pc_wr_en=1 in EXECUTE, next state FETCH.
//  4. JAL: EXECUTE has pc_src=2, reg_wr_en=1, link_sel=1, writeback_src=2; 3-cycle total.
//  5. opcode 0x3F -> HALT, halt_cause=1; later imem_ready pulses produce no imem_req or strobes.
//  6. TIMEOUT_W=3, imem_ready=0 held -> HALT after 7 wait cycles, cause 2; rst_n low mid-MEMORY -> all outputs 0 immediately.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/handshake bundle between the multi-cycle FSM and the datapath
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       ir_wr_en;
  logic       pc_wr_en;
  logic       reg_wr_en;
  logic       mem_wr_en;
  logic [1:0] pc_src;
  logic [1:0] writeback_src;
  logic       reg_dst;
  logic       link_sel;
  logic       alu_src_b;
  logic       ext_sel;
  logic [2:0] alu_command;
  logic [2:0] state;
  logic [1:0] halt_cause;

  modport master (
    input  opcode, funct, alu_zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, ir_wr_en, pc_wr_en, reg_wr_en, mem_wr_en,
    output pc_src, writeback_src, reg_dst, link_sel, alu_src_b, ext_sel,
    output alu_command, state, halt_cause
  );

  modport slave (
    output opcode, funct, alu_zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, ir_wr_en, pc_wr_en, reg_wr_en, mem_wr_en,
    input  pc_src, writeback_src, reg_dst, link_sel, alu_src_b, ext_sel,
    input  alu_command, state, halt_cause
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS-subset control FSM
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK; illegal ops and memory timeouts park the core in HALT.
module multicycle_controller #(
  parameter int TIMEOUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);
  typedef enum logic [2:0] {
    RESET     = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] WAIT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  stateT                stateQ, stateNext;
  logic [5:0]           opReg, functReg;
  logic [TIMEOUT_W-1:0] waitCnt;
  logic [1:0]           haltCause, haltCauseNext;
  logic                 legalOp;
  logic                 waiting;

  always_comb begin
    legalOp = 1'b0;
    case (opReg)
      OP_RTYPE: legalOp = (functReg == FN_ADD) || (functReg == FN_SUB) ||
                          (functReg == FN_SLT) || (functReg == FN_JR);
      OP_LW, OP_SW, OP_XORI, OP_BNE, OP_J, OP_JAL: legalOp = 1'b1;
      default: legalOp = 1'b0;
    endcase
  end

  assign waiting = ((stateQ == FETCH)  && !bus.imem_ready) ||
                   ((stateQ == MEMORY) && !bus.dmem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= RESET;
      opReg     <= '0;
      functReg  <= '0;
      waitCnt   <= '0;
      haltCause <= CAUSE_NONE;
    end else begin
      stateQ    <= stateNext;
      haltCause <= haltCauseNext;
      if ((stateQ == FETCH) && bus.imem_ready) begin
        opReg    <= bus.opcode;
        functReg <= bus.funct;
      end
      if (stateNext != stateQ)
        waitCnt <= '0;
      else if (waiting && (waitCnt != WAIT_MAX))
        waitCnt <= waitCnt + WAIT_ONE;
    end
  end

  always_comb begin
    stateNext         = stateQ;
    haltCauseNext     = haltCause;
    bus.imem_req      = 1'b0;
    bus.dmem_req      = 1'b0;
    bus.ir_wr_en      = 1'b0;
    bus.pc_wr_en      = 1'b0;
    bus.reg_wr_en     = 1'b0;
    bus.mem_wr_en     = 1'b0;
    bus.pc_src        = 2'd0;
    bus.writeback_src = 2'd0;
    bus.reg_dst       = 1'b0;
    bus.link_sel      = 1'b0;
    bus.alu_src_b     = 1'b0;
    bus.ext_sel       = 1'b0;
    bus.alu_command   = ALU_ADD;

    case (stateQ)
      RESET: stateNext = FETCH;

      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_wr_en = 1'b1;
          stateNext    = DECODE;
        end else if (waitCnt == WAIT_LAST) begin
          stateNext     = HALT;
          haltCauseNext = CAUSE_IMEM;
        end
      end

      DECODE: begin
        if (legalOp) begin
          stateNext = EXECUTE;
        end else begin
          stateNext     = HALT;
          haltCauseNext = CAUSE_ILLEGAL;
        end
      end

      EXECUTE: begin
        case (opReg)
          OP_RTYPE: begin
            stateNext = WRITEBACK;
            case (functReg)
              FN_SUB:  bus.alu_command = ALU_SUB;
              FN_SLT:  bus.alu_command = ALU_SLT;
              FN_JR: begin
                bus.pc_wr_en = 1'b1;
                bus.pc_src   = 2'd1;
                stateNext    = FETCH;
              end
              default: bus.alu_command = ALU_ADD;
            endcase
          end
          OP_LW, OP_SW: begin
            bus.alu_src_b = 1'b1;
            bus.ext_sel   = 1'b1;
            stateNext     = MEMORY;
          end
          OP_XORI: begin
            bus.alu_command = ALU_XOR;
            bus.alu_src_b   = 1'b1;
            stateNext       = WRITEBACK;
          end
          OP_BNE: begin
            bus.alu_command = ALU_SUB;
            bus.ext_sel     = 1'b1;
            bus.pc_wr_en    = 1'b1;
            bus.pc_src      = bus.alu_zero ? 2'd0 : 2'd3;
            stateNext       = FETCH;
          end
          OP_JAL: begin
            bus.pc_wr_en      = 1'b1;
            bus.pc_src        = 2'd2;
            bus.reg_wr_en     = 1'b1;
            bus.link_sel      = 1'b1;
            bus.writeback_src = 2'd2;
            stateNext         = FETCH;
          end
          default: begin
            bus.pc_wr_en = 1'b1;
            bus.pc_src   = 2'd2;
            stateNext    = FETCH;
          end
        endcase
      end

      MEMORY: begin
        // Address computation stays selected so the ALU result is stable through the access.
        bus.dmem_req  = 1'b1;
        bus.alu_src_b = 1'b1;
        bus.ext_sel   = 1'b1;
        bus.mem_wr_en = (opReg == OP_SW);
        if (bus.dmem_ready) begin
          if (opReg == OP_SW) begin
            bus.pc_wr_en = 1'b1;
            stateNext    = FETCH;
          end else begin
            stateNext = WRITEBACK;
          end
        end else if (waitCnt == WAIT_LAST) begin
          stateNext     = HALT;
          haltCauseNext = CAUSE_DMEM;
        end
      end

      WRITEBACK: begin
        bus.reg_wr_en     = 1'b1;
        bus.pc_wr_en      = 1'b1;
        bus.reg_dst       = (opReg != OP_RTYPE);
        bus.writeback_src = (opReg == OP_LW) ? 2'd1 : 2'd0;
        stateNext         = FETCH;
      end

      default: stateNext = HALT;
    endcase
  end

  assign bus.state      = stateQ;
  assign bus.halt_cause = haltCause;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;

  multicycle_controller_if bus();

  multicycle_controller #(.TIMEOUT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Entered during a FETCH cycle; leaves the bench inside the following DECODE cycle.
  task automatic doFetch(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode     = op;
    bus.funct      = fn;
    bus.imem_ready = 1'b1;
    #1;
    checkValue("fetch_state", bus.state, 1);
    checkValue("fetch_ir_wr", bus.ir_wr_en, 1);
    nextCycle();
    bus.imem_ready = 1'b0;
    #1;
    checkValue("decode_state", bus.state, 2);
    checkValue("decode_strobes", {bus.ir_wr_en, bus.pc_wr_en, bus.reg_wr_en}, 0);
  endtask

  // Leaves the bench inside the first FETCH cycle after reset.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkValue("rst_state", bus.state, 0);
    checkValue("rst_cause", bus.halt_cause, 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkValue("rst_to_fetch", bus.state, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checkCount     = 0;
    failCount      = 0;
    rst_n          = 1'b0;
    bus.opcode     = '0;
    bus.funct      = '0;
    bus.alu_zero   = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;

    nextCycle();
    checkValue("reset_state", bus.state, 0);
    checkValue("reset_outputs", {bus.imem_req, bus.pc_wr_en, bus.reg_wr_en, bus.halt_cause}, 0);
    rst_n = 1'b1;
    #1;
    checkValue("release_state", bus.state, 0);
    nextCycle();
    checkValue("first_fetch", bus.state, 1);
    checkValue("first_imem_req", bus.imem_req, 1);

    // ADD: FETCH, DECODE, EXECUTE, WRITEBACK
    doFetch(6'h00, 6'h20);
    nextCycle();
    checkValue("add_ex_state", bus.state, 3);
    checkValue("add_ex_alu", bus.alu_command, 0);
    checkValue("add_ex_strobes", {bus.pc_wr_en, bus.reg_wr_en}, 0);
    nextCycle();
    checkValue("add_wb_state", bus.state, 5);
    checkValue("add_wb_strobes", {bus.pc_wr_en, bus.reg_wr_en}, 3);
    checkValue("add_wb_sel", {bus.pc_src, bus.reg_dst, bus.writeback_src}, 0);
    nextCycle();
    checkValue("add_done", bus.state, 1);

    // LW with dmem_ready delayed 3 cycles
    doFetch(6'h23, 6'h00);
    nextCycle();
    checkValue("lw_ex", {bus.state, bus.alu_command, bus.alu_src_b, bus.ext_sel}, {3'd3, 3'd0, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkValue("lw_mem_wait", {bus.state, bus.dmem_req, bus.mem_wr_en}, {3'd4, 1'b1, 1'b0});
    end
    nextCycle();
    bus.dmem_ready = 1'b1;
    #1;
    checkValue("lw_mem_ready", {bus.state, bus.dmem_req, bus.pc_wr_en}, {3'd4, 1'b1, 1'b0});
    nextCycle();
    bus.dmem_ready = 1'b0;
    #1;
    checkValue("lw_wb", {bus.state, bus.reg_dst, bus.writeback_src, bus.reg_wr_en}, {3'd5, 1'b1, 2'd1, 1'b1});
    nextCycle();
    checkValue("lw_done", bus.state, 1);

    // SW: PC advances on dmem_ready, no WRITEBACK
    doFetch(6'h2B, 6'h00);
    nextCycle();
    nextCycle();
    bus.dmem_ready = 1'b1;
    #1;
    checkValue("sw_mem", {bus.state, bus.mem_wr_en, bus.pc_wr_en, bus.pc_src, bus.reg_wr_en}, {3'd4, 1'b1, 1'b1, 2'd0, 1'b0});
    nextCycle();
    bus.dmem_ready = 1'b0;
    #1;
    checkValue("sw_done", bus.state, 1);

    // BNE taken then not taken
    doFetch(6'h05, 6'h00);
    nextCycle();
    bus.alu_zero = 1'b0;
    #1;
    checkValue("bne_taken", {bus.state, bus.pc_wr_en, bus.pc_src, bus.alu_command}, {3'd3, 1'b1, 2'd3, 3'd1});
    nextCycle();
    checkValue("bne_done", bus.state, 1);
    doFetch(6'h05, 6'h00);
    nextCycle();
    bus.alu_zero = 1'b1;
    #1;
    checkValue("bne_not_taken", {bus.pc_wr_en, bus.pc_src}, {1'b1, 2'd0});
    nextCycle();
    bus.alu_zero = 1'b0;
    checkValue("bne2_done", bus.state, 1);

    // JAL and JR finish in EXECUTE
    doFetch(6'h03, 6'h00);
    nextCycle();
    checkValue("jal_ex", {bus.state, bus.pc_wr_en, bus.pc_src, bus.reg_wr_en, bus.link_sel, bus.writeback_src},
               {3'd3, 1'b1, 2'd2, 1'b1, 1'b1, 2'd2});
    nextCycle();
    checkValue("jal_done", bus.state, 1);
    doFetch(6'h00, 6'h08);
    nextCycle();
    checkValue("jr_ex", {bus.pc_wr_en, bus.pc_src, bus.reg_wr_en}, {1'b1, 2'd1, 1'b0});
    nextCycle();
    checkValue("jr_done", bus.state, 1);

    // XORI: zero-extended immediate, writes rt
    doFetch(6'h0E, 6'h00);
    nextCycle();
    checkValue("xori_ex", {bus.alu_command, bus.alu_src_b, bus.ext_sel}, {3'd2, 1'b1, 1'b0});
    nextCycle();
    checkValue("xori_wb", {bus.state, bus.reg_dst, bus.writeback_src}, {3'd5, 1'b1, 2'd0});
    nextCycle();

    // Illegal opcode halts; ready pulses are then ignored
    doFetch(6'h3F, 6'h00);
    nextCycle();
    checkValue("illegal_halt", {bus.state, bus.halt_cause}, {3'd6, 2'd1});
    for (int i = 0; i < 3; i++) begin
      bus.imem_ready = 1'b1;
      #1;
      checkValue("halt_quiet", {bus.imem_req, bus.ir_wr_en, bus.pc_wr_en, bus.reg_wr_en, bus.state}, {4'd0, 3'd6});
      nextCycle();
      bus.imem_ready = 1'b0;
    end

    // imem timeout: 7 FETCH cycles without ready
    doReset();
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      checkValue("imem_wait", bus.state, 1);
    end
    nextCycle();
    checkValue("imem_timeout", {bus.state, bus.halt_cause, bus.imem_req}, {3'd6, 2'd2, 1'b0});

    // ready on the final wait cycle wins over the timeout
    doReset();
    repeat (6) nextCycle();
    doFetch(6'h00, 6'h22);
    nextCycle();
    checkValue("sub_ex_alu", bus.alu_command, 1);
    nextCycle();
    nextCycle();

    // dmem timeout: 7 MEMORY cycles without ready
    doFetch(6'h23, 6'h00);
    nextCycle();
    for (int i = 0; i < 7; i++) begin
      nextCycle();
      checkValue("dmem_wait", bus.state, 4);
    end
    nextCycle();
    checkValue("dmem_timeout", {bus.state, bus.halt_cause, bus.dmem_req}, {3'd6, 2'd3, 1'b0});

    // asynchronous reset in the middle of a store
    doReset();
    doFetch(6'h2B, 6'h00);
    nextCycle();
    nextCycle();
    checkValue("sw_mid_mem", {bus.state, bus.mem_wr_en}, {3'd4, 1'b1});
    rst_n = 1'b0;
    #1;
    checkValue("async_reset_outputs",
               {bus.imem_req, bus.dmem_req, bus.ir_wr_en, bus.pc_wr_en, bus.reg_wr_en, bus.mem_wr_en,
                bus.pc_src, bus.writeback_src, bus.reg_dst, bus.link_sel, bus.alu_src_b, bus.ext_sel,
                bus.alu_command, bus.state, bus.halt_cause}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
